// File: rtl/meteor_spawner_pkg.sv
// Shared definitions for the meteor spawner: FSM encoding, the screen window
// bounds, and where the column and speed fields sit in the LFSR word.
package meteor_spawner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SEEK  = 2'd2,
        ST_OFFER = 2'd3
    } state_t;

    // Horizontal spawn window; the upstream window-check stage compares
    // against these bounds and delivers the result as in_view.
    localparam int unsigned WIN_LO = 150;
    localparam int unsigned WIN_HI = 520;

    // Field positions inside the 16-bit LFSR word.
    localparam int unsigned X_LSB   = 0;
    localparam int unsigned X_MSB   = 9;
    localparam int unsigned SPD_LSB = 14;
    localparam int unsigned SPD_MSB = 15;

    localparam int unsigned X_W   = X_MSB - X_LSB + 1;
    localparam int unsigned SPD_W = SPD_MSB - SPD_LSB + 1;

endpackage

// File: rtl/meteor_spawner_if.sv
// Spawn offer handshake between the spawner (master) and a meteor slot (slave).
interface meteor_spawner_if;
    import meteor_spawner_pkg::*;

    logic             spawn_valid;
    logic [X_W-1:0]   spawn_x;
    logic [SPD_W-1:0] spawn_speed;
    logic             spawn_ack;

    modport master (
        output spawn_valid,
        output spawn_x,
        output spawn_speed,
        input  spawn_ack
    );

    modport slave (
        input  spawn_valid,
        input  spawn_x,
        input  spawn_speed,
        output spawn_ack
    );

endinterface

// File: rtl/meteor_spawner_spawn_timer.sv
// Frame-period timer: counts frame ticks and flags the tick that completes
// one SPAWN_PERIOD. The counter restarts on clear or on completion.
module spawn_timer #(
    parameter int unsigned SPAWN_PERIOD = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic period_done
);

    localparam logic [7:0] LAST_CNT = 8'(SPAWN_PERIOD - 1);

    logic [7:0] frame_cnt_q;
    logic [7:0] frame_cnt_d;

    // Period completes on the tick that arrives while the counter sits at its last value.
    always_comb begin
        period_done = tick && (frame_cnt_q == LAST_CNT);
    end

    // Next count: clear wins, completion wraps to zero, otherwise count ticks.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        frame_cnt_d = frame_cnt_q;
        if (clear || period_done) begin
            frame_cnt_d = '0;
        end else if (tick) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/meteor_spawner.sv
// Meteor spawner: waits SPAWN_PERIOD frames, searches the LFSR stream for an
// in-window column (falling back to FALLBACK_X), then offers the spawn over a
// valid/ack handshake and counts accepted spawns.
module meteor_spawner
    import meteor_spawner_pkg::*;
#(
    parameter int unsigned SPAWN_PERIOD = 60,
    parameter int unsigned MAX_TRIES    = 8,
    parameter int unsigned FALLBACK_X   = 335
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    frame_tick,
    input  logic [15:0]             lfsr,
    input  logic                    in_view,
    meteor_spawner_if.master        spawn_if,
    output logic [7:0]              spawn_count
);

    localparam logic [3:0]     TRIES_LAST = 4'(MAX_TRIES - 1);
    localparam logic [X_W-1:0] FALLBACK   = X_W'(FALLBACK_X);

    state_t           state_q,       state_d;
    logic             spawn_valid_q, spawn_valid_d;
    logic [X_W-1:0]   spawn_x_q,     spawn_x_d;
    logic [SPD_W-1:0] spawn_speed_q, spawn_speed_d;
    logic [7:0]       spawn_count_q, spawn_count_d;
    logic [3:0]       tries_q,       tries_d;

    logic timer_clear;
    logic timer_tick;
    logic period_done;

    // The timer only runs in WAIT, so it restarts from zero on every WAIT entry.
    assign timer_clear = (state_q != ST_WAIT);
    assign timer_tick  = (state_q == ST_WAIT) && enable && frame_tick;

    spawn_timer #(
        .SPAWN_PERIOD (SPAWN_PERIOD)
    ) u_spawn_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (timer_clear),
        .tick        (timer_tick),
        .period_done (period_done)
    );

    // Next-state and registered-output logic for the spawn FSM.
    always_comb begin
        state_d       = state_q;
        spawn_valid_d = spawn_valid_q;
        spawn_x_d     = spawn_x_q;
        spawn_speed_d = spawn_speed_q;
        spawn_count_d = spawn_count_q;
        tries_d       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (period_done) begin
                    state_d = ST_SEEK;
                end
            end

            ST_SEEK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (in_view) begin
                    spawn_x_d     = lfsr[X_MSB:X_LSB];
                    spawn_speed_d = lfsr[SPD_MSB:SPD_LSB];
                    spawn_valid_d = 1'b1;
                    state_d       = ST_OFFER;
                end else if (tries_q == TRIES_LAST) begin
                    spawn_x_d     = FALLBACK;
                    spawn_speed_d = lfsr[SPD_MSB:SPD_LSB];
                    spawn_valid_d = 1'b1;
                    state_d       = ST_OFFER;
                end else begin
                    tries_d = tries_q + 4'd1;
                end
            end

            ST_OFFER: begin
                // The offer survives enable=0; only acceptance ends it.
                if (spawn_if.spawn_ack) begin
                    spawn_valid_d = 1'b0;
                    if (spawn_count_q != 8'hFF) begin
                        spawn_count_d = spawn_count_q + 8'd1;
                    end
                    state_d = enable ? ST_WAIT : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides every input.
    always_ff @(posedge clk) begin
        // NOTE: all control and datapath registers are reset so the offer bus comes up defined.
        if (reset) begin
            state_q       <= ST_IDLE;
            spawn_valid_q <= 1'b0;
            spawn_x_q     <= '0;
            spawn_speed_q <= '0;
            spawn_count_q <= '0;
            tries_q       <= '0;
        end else begin
            state_q       <= state_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_x_q     <= spawn_x_d;
            spawn_speed_q <= spawn_speed_d;
            spawn_count_q <= spawn_count_d;
            tries_q       <= tries_d;
        end
    end

    assign spawn_if.spawn_valid = spawn_valid_q;
    assign spawn_if.spawn_x     = spawn_x_q;
    assign spawn_if.spawn_speed = spawn_speed_q;
    assign spawn_count          = spawn_count_q;

endmodule

// File: tb/tb_meteor_spawner.sv
// Directed bench for meteor_spawner with SPAWN_PERIOD=3, MAX_TRIES=8, FALLBACK_X=335.
module tb_meteor_spawner;
    import meteor_spawner_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_tick;
    logic [15:0] lfsr;
    logic        in_view;
    logic [7:0]  spawn_count;

    meteor_spawner_if spawn_if ();

    meteor_spawner #(
        .SPAWN_PERIOD (3),
        .MAX_TRIES    (8),
        .FALLBACK_X   (335)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .lfsr        (lfsr),
        .in_view     (in_view),
        .spawn_if    (spawn_if.master),
        .spawn_count (spawn_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        enable             = 1'b0;
        frame_tick         = 1'b0;
        in_view            = 1'b0;
        lfsr               = 16'h0000;
        spawn_if.spawn_ack = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    // n one-cycle frame_tick pulses separated by one idle cycle; returns right after the last pulse edge.
    task automatic tick_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            if (i < n - 1) step(1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (spawn_if.spawn_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", spawn_if.spawn_valid); end
        n_cmp++; if (spawn_if.spawn_x !== 10'd0) begin n_err++; $display("FAIL reset_x: got %0d want 0", spawn_if.spawn_x); end
        n_cmp++; if (spawn_if.spawn_speed !== 2'd0) begin n_err++; $display("FAIL reset_speed: got %0d want 0", spawn_if.spawn_speed); end
        n_cmp++; if (spawn_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", spawn_count); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_timing();
        do_reset();
        enable  = 1'b1;
        lfsr    = 16'd300;
        in_view = 1'b1;
        step(1);
        n_cmp++; if (dut.state_q !== ST_WAIT) begin n_err++; $display("FAIL idle_to_wait: got %0d want %0d", dut.state_q, ST_WAIT); end
        // Acks outside OFFER must not count.
        spawn_if.spawn_ack = 1'b1;
        tick_pulses(2);
        spawn_if.spawn_ack = 1'b0;
        n_cmp++; if (dut.state_q !== ST_WAIT) begin n_err++; $display("FAIL wait_after_2_ticks: got %0d want %0d", dut.state_q, ST_WAIT); end
        n_cmp++; if (spawn_count !== 8'd0) begin n_err++; $display("FAIL ack_outside_offer: got %0d want 0", spawn_count); end
        step(1);
        tick_pulses(1);
        n_cmp++; if (dut.state_q !== ST_SEEK) begin n_err++; $display("FAIL seek_after_3_ticks: got %0d want %0d", dut.state_q, ST_SEEK); end
        n_cmp++; if (spawn_if.spawn_valid !== 1'b0) begin n_err++; $display("FAIL valid_in_seek: got %b want 0", spawn_if.spawn_valid); end
        step(1);
        n_cmp++; if (spawn_if.spawn_valid !== 1'b1) begin n_err++; $display("FAIL timing_valid: got %b want 1", spawn_if.spawn_valid); end
        n_cmp++; if (spawn_if.spawn_x !== 10'd300) begin n_err++; $display("FAIL timing_x: got %0d want 300", spawn_if.spawn_x); end
        n_cmp++; if (spawn_if.spawn_speed !== 2'd0) begin n_err++; $display("FAIL timing_speed0: got %0d want 0", spawn_if.spawn_speed); end
        // Offer must stay put while lfsr moves and frame ticks arrive.
        lfsr       = 16'hFFFF;
        frame_tick = 1'b1;
        step(4);
        frame_tick = 1'b0;
        n_cmp++; if (spawn_if.spawn_valid !== 1'b1) begin n_err++; $display("FAIL offer_held_valid: got %b want 1", spawn_if.spawn_valid); end
        n_cmp++; if (spawn_if.spawn_x !== 10'd300 || spawn_if.spawn_speed !== 2'd0) begin n_err++; $display("FAIL offer_held_fields: got x=%0d spd=%0d want x=300 spd=0", spawn_if.spawn_x, spawn_if.spawn_speed); end
        spawn_if.spawn_ack = 1'b1;
        step(1);
        spawn_if.spawn_ack = 1'b0;
        n_cmp++; if (dut.state_q !== ST_WAIT || spawn_count !== 8'd1) begin n_err++; $display("FAIL ack_to_wait: got state=%0d count=%0d want state=%0d count=1", dut.state_q, spawn_count, ST_WAIT); end
    endtask

    task automatic test_speed();
        do_reset();
        enable  = 1'b1;
        lfsr    = 16'hC1F4;
        in_view = 1'b1;
        step(1);
        tick_pulses(3);
        step(1);
        n_cmp++; if (spawn_if.spawn_x !== 10'd500) begin n_err++; $display("FAIL speed_x: got %0d want 500", spawn_if.spawn_x); end
        n_cmp++; if (spawn_if.spawn_speed !== 2'd3) begin n_err++; $display("FAIL speed_code: got %0d want 3", spawn_if.spawn_speed); end
        spawn_if.spawn_ack = 1'b1;
        step(1);
        spawn_if.spawn_ack = 1'b0;
        n_cmp++; if (spawn_if.spawn_valid !== 1'b0) begin n_err++; $display("FAIL speed_valid_drop: got %b want 0", spawn_if.spawn_valid); end
        n_cmp++; if (spawn_count !== 8'd1) begin n_err++; $display("FAIL speed_count: got %0d want 1", spawn_count); end
    endtask

    task automatic test_fallback();
        do_reset();
        enable  = 1'b1;
        lfsr    = 16'h4123;
        in_view = 1'b0;
        step(1);
        tick_pulses(3);
        step(7);
        n_cmp++; if (spawn_if.spawn_valid !== 1'b0 || dut.state_q !== ST_SEEK) begin n_err++; $display("FAIL fallback_early: got valid=%b state=%0d want valid=0 state=%0d", spawn_if.spawn_valid, dut.state_q, ST_SEEK); end
        step(1);
        n_cmp++; if (spawn_if.spawn_valid !== 1'b1) begin n_err++; $display("FAIL fallback_valid: got %b want 1", spawn_if.spawn_valid); end
        n_cmp++; if (spawn_if.spawn_x !== 10'd335) begin n_err++; $display("FAIL fallback_x: got %0d want 335", spawn_if.spawn_x); end
        n_cmp++; if (spawn_if.spawn_speed !== 2'd1) begin n_err++; $display("FAIL fallback_speed: got %0d want 1", spawn_if.spawn_speed); end
        spawn_if.spawn_ack = 1'b1;
        step(1);
        spawn_if.spawn_ack = 1'b0;
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable  = 1'b1;
        lfsr    = 16'd200;
        in_view = 1'b1;
        step(1);
        tick_pulses(3);
        step(1);
        enable = 1'b0;
        step(3);
        n_cmp++; if (spawn_if.spawn_valid !== 1'b1 || spawn_if.spawn_x !== 10'd200) begin n_err++; $display("FAIL offer_survives_enable: got valid=%b x=%0d want valid=1 x=200", spawn_if.spawn_valid, spawn_if.spawn_x); end
        spawn_if.spawn_ack = 1'b1;
        step(1);
        spawn_if.spawn_ack = 1'b0;
        n_cmp++; if (dut.state_q !== ST_IDLE || spawn_if.spawn_valid !== 1'b0 || spawn_count !== 8'd1) begin n_err++; $display("FAIL ack_to_idle: got state=%0d valid=%b count=%0d want state=%0d valid=0 count=1", dut.state_q, spawn_if.spawn_valid, spawn_count, ST_IDLE); end
        // Drop enable mid-WAIT after one tick; the partial count must be discarded.
        enable = 1'b1;
        step(1);
        tick_pulses(1);
        enable = 1'b0;
        step(1);
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL wait_drop_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
        enable = 1'b1;
        step(1);
        tick_pulses(2);
        step(1);
        n_cmp++; if (dut.state_q !== ST_WAIT || spawn_if.spawn_valid !== 1'b0) begin n_err++; $display("FAIL wait_count_discarded: got state=%0d valid=%b want state=%0d valid=0", dut.state_q, spawn_if.spawn_valid, ST_WAIT); end
        // Drop enable mid-SEEK.
        in_view = 1'b0;
        tick_pulses(1);
        step(2);
        enable = 1'b0;
        step(1);
        n_cmp++; if (dut.state_q !== ST_IDLE || spawn_if.spawn_valid !== 1'b0) begin n_err++; $display("FAIL seek_drop_idle: got state=%0d valid=%b want state=%0d valid=0", dut.state_q, spawn_if.spawn_valid, ST_IDLE); end
    endtask

    task automatic test_saturation();
        int acc;
        int cyc;
        bit seen255;
        do_reset();
        enable             = 1'b1;
        lfsr               = 16'd400;
        in_view            = 1'b1;
        frame_tick         = 1'b1;
        spawn_if.spawn_ack = 1'b1;
        acc     = 0;
        cyc     = 0;
        seen255 = 1'b0;
        while (acc < 260 && cyc < 5000) begin
            if (spawn_if.spawn_valid === 1'b1) acc++;
            step(1);
            cyc++;
            if (acc == 255 && !seen255) begin
                seen255 = 1'b1;
                n_cmp++; if (spawn_count !== 8'd255) begin n_err++; $display("FAIL count_at_255: got %0d want 255", spawn_count); end
            end
        end
        n_cmp++; if (acc != 260) begin n_err++; $display("FAIL saturation_timeout: got %0d accepts want 260", acc); end
        n_cmp++; if (spawn_count !== 8'd255) begin n_err++; $display("FAIL count_saturated: got %0d want 255", spawn_count); end
    endtask

    task automatic test_reset_mid_offer();
        int cyc;
        spawn_if.spawn_ack = 1'b0;
        cyc = 0;
        while (spawn_if.spawn_valid !== 1'b1 && cyc < 50) begin
            step(1);
            cyc++;
        end
        n_cmp++; if (spawn_if.spawn_valid !== 1'b1) begin n_err++; $display("FAIL reach_offer_timeout: got valid=%b want 1", spawn_if.spawn_valid); end
        frame_tick         = 1'b0;
        reset              = 1'b1;
        spawn_if.spawn_ack = 1'b1;
        step(1);
        reset              = 1'b0;
        spawn_if.spawn_ack = 1'b0;
        n_cmp++; if (spawn_if.spawn_valid !== 1'b0 || spawn_count !== 8'd0 || dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL reset_mid_offer: got valid=%b count=%0d state=%0d want valid=0 count=0 state=%0d", spawn_if.spawn_valid, spawn_count, dut.state_q, ST_IDLE); end
        n_cmp++; if (spawn_if.spawn_x !== 10'd0) begin n_err++; $display("FAIL reset_mid_offer_x: got %0d want 0", spawn_if.spawn_x); end
        // Reset in the middle of a search.
        in_view = 1'b0;
        step(1);
        tick_pulses(3);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_cmp++; if (dut.state_q !== ST_IDLE || dut.tries_q !== 4'd0) begin n_err++; $display("FAIL reset_mid_seek: got state=%0d tries=%0d want state=%0d tries=0", dut.state_q, dut.tries_q, ST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_speed();
        test_fallback();
        test_enable_drop();
        test_saturation();
        test_reset_mid_offer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
